// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences one scope acquisition (pre-trigger fill, arm, trigger, post fill, stop)
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   sample_en                 ADC sample valid strobe
//   arm, abort, force_trig    start / cancel / software trigger pulses
//   rd_ack, single_shot       readout done pulse, stay-in-DONE select
//   pretrig_len               pre-trigger sample count, latched at start
//   trig_in                   trigger level; rising edge is the trigger event
//   trig_en, trig_ss_rst      trigger block enable and single-shot reset pulse
//   wr_en, wr_addr            capture RAM write port
//   trig_addr, rd_start       trigger sample address, oldest valid sample address
//   busy, done                acquisition in progress / buffer complete
module capture_ctrl #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_en,
   input  logic              arm,
   input  logic              abort,
   input  logic              force_trig,
   input  logic              rd_ack,
   input  logic              single_shot,
   input  logic [ADDR_W-1:0] pretrig_len,
   input  logic              trig_in,
   output logic              trig_en,
   output logic              trig_ss_rst,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] trig_addr,
   output logic [ADDR_W-1:0] rd_start,
   output logic              busy,
   output logic              done
);
   localparam int DEPTH = 2 ** ADDR_W;
   typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, ARMED = 3'd2, POST = 3'd3, DONE = 3'd4} state_t;
   state_t            state;
   logic              trig_d;
   logic              trig_evt;
   logic              start;
   logic [ADDR_W-1:0] plen;
   logic [ADDR_W-1:0] pre_cnt;
   logic [ADDR_W:0]   post_cnt;
   logic [ADDR_W:0]   post_nxt;
   logic [ADDR_W:0]   target;
   assign busy     = state inside {PRE, ARMED, POST};
   assign done     = state == DONE;
   assign trig_en  = busy;
   assign wr_en    = sample_en & busy & ~abort;
   assign trig_evt = (trig_in & ~trig_d) | force_trig;
   assign start    = ((state == IDLE || state == DONE) && arm) || (state == DONE && rd_ack && !single_shot);
   assign target   = (ADDR_W+1)'(DEPTH) - {1'b0, plen};
   assign post_nxt = post_cnt + (ADDR_W+1)'(wr_en);
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         trig_d      <= 1'b0;
         trig_ss_rst <= 1'b0;
         wr_addr     <= '0;
         trig_addr   <= '0;
         rd_start    <= '0;
         plen        <= '0;
         pre_cnt     <= '0;
         post_cnt    <= '0;
      end else begin
         trig_d      <= trig_in;
         trig_ss_rst <= 1'b0;
         if (wr_en) wr_addr <= wr_addr + ADDR_W'(1);
         if (abort) state <= IDLE;
         else if (start) begin
            state       <= PRE;
            wr_addr     <= '0;
            plen        <= pretrig_len;
            pre_cnt     <= '0;
            trig_ss_rst <= 1'b1;
         end else begin
            case (state)
               PRE: begin
                  if (wr_en) pre_cnt <= pre_cnt + ADDR_W'(1);
                  if (plen == '0 || (wr_en && pre_cnt + ADDR_W'(1) == plen)) state <= ARMED;
               end
               ARMED: begin
                  if (trig_evt) begin
                     trig_addr <= wr_addr;
                     rd_start  <= wr_addr - plen;
                     post_cnt  <= (ADDR_W+1)'(wr_en);
                     state     <= (wr_en && target == (ADDR_W+1)'(1)) ? DONE : POST;
                  end
               end
               POST: begin
                  if (wr_en) post_cnt <= post_nxt;
                  if (wr_en && post_nxt == target) state <= DONE;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed self-checking bench for capture_ctrl with ADDR_W=4
module tb_capture_ctrl;
   logic       clk = 1'b0;
   logic       rst, sample_en, arm, abort, force_trig, rd_ack, single_shot, trig_in;
   logic [3:0] pretrig_len;
   logic       trig_en, trig_ss_rst, wr_en, busy, done;
   logic [3:0] wr_addr, trig_addr, rd_start;
   int         passed = 0;
   int         total = 0;
   capture_ctrl #(.ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .arm(arm), .abort(abort),
      .force_trig(force_trig), .rd_ack(rd_ack), .single_shot(single_shot),
      .pretrig_len(pretrig_len), .trig_in(trig_in), .trig_en(trig_en),
      .trig_ss_rst(trig_ss_rst), .wr_en(wr_en), .wr_addr(wr_addr),
      .trig_addr(trig_addr), .rd_start(rd_start), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         {sample_en, arm, abort, force_trig, rd_ack, single_shot, trig_in} = 7'($urandom);
         pretrig_len = 4'($urandom);
         tick;
      end
      #1;
      total++; if ({busy, done, wr_en, trig_en, trig_ss_rst} !== 5'b0) $display("FAIL reset_flags got busy=%b done=%b wr_en=%b trig_en=%b ss=%b exp all 0", busy, done, wr_en, trig_en, trig_ss_rst); else passed++;
      total++; if ({wr_addr, trig_addr, rd_start} !== 12'h0) $display("FAIL reset_addrs got wr=%0d trig=%0d rd=%0d exp 0", wr_addr, trig_addr, rd_start); else passed++;
      {sample_en, arm, abort, force_trig, rd_ack, single_shot, trig_in} = 7'b0;
      pretrig_len = 4'd0;
      tick;
      rst = 1'b0;
      tick;
      #1;
      total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_idle got busy=%b done=%b exp 0 0", busy, done); else passed++;
   endtask
   task automatic test_normal;
      single_shot = 1'b1; pretrig_len = 4'd4; sample_en = 1'b1; arm = 1'b1;
      tick;
      arm = 1'b0;
      for (int i = 0; i < 14; i++) begin
         #1;
         total++; if (wr_en !== 1'b1 || wr_addr !== 4'(i)) $display("FAIL t2_fill i=%0d got wr_en=%b addr=%0d exp 1 %0d", i, wr_en, wr_addr, i); else passed++;
         total++; if (trig_ss_rst !== (i == 0)) $display("FAIL t2_ss_rst i=%0d got %b exp %b", i, trig_ss_rst, i == 0); else passed++;
         tick;
      end
      trig_in = 1'b1;
      for (int j = 0; j < 12; j++) begin
         #1;
         total++; if (wr_en !== 1'b1 || wr_addr !== 4'(14 + j)) $display("FAIL t2_post j=%0d got wr_en=%b addr=%0d exp 1 %0d", j, wr_en, wr_addr, (14 + j) % 16); else passed++;
         tick;
         if (j == 0) begin
            total++; if (trig_addr !== 4'd14 || rd_start !== 4'd10) $display("FAIL t2_trig got trig=%0d rd=%0d exp 14 10", trig_addr, rd_start); else passed++;
         end
      end
      #1;
      total++; if (done !== 1'b1 || busy !== 1'b0 || trig_en !== 1'b0 || wr_en !== 1'b0) $display("FAIL t2_done got done=%b busy=%b trig_en=%b wr_en=%b exp 1 0 0 0", done, busy, trig_en, wr_en); else passed++;
      total++; if (wr_addr !== 4'd10) $display("FAIL t2_hold_addr got %0d exp 10", wr_addr); else passed++;
      trig_in = 1'b0;
      tick; tick;
      total++; if (wr_en !== 1'b0 || done !== 1'b1 || trig_addr !== 4'd14) $display("FAIL t2_stay got wr_en=%b done=%b trig=%0d exp 0 1 14", wr_en, done, trig_addr); else passed++;
   endtask
   task automatic test_force_zero_pre;
      pretrig_len = 4'd0; sample_en = 1'b1; arm = 1'b1;
      tick;
      arm = 1'b0;
      #1;
      total++; if (busy !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 4'd0) $display("FAIL t3_pre got busy=%b wr_en=%b addr=%0d exp 1 1 0", busy, wr_en, wr_addr); else passed++;
      tick;
      sample_en = 1'b0;
      tick;
      force_trig = 1'b1;
      tick;
      force_trig = 1'b0;
      total++; if (trig_addr !== 4'd1 || rd_start !== 4'd1) $display("FAIL t3_trig got trig=%0d rd=%0d exp 1 1", trig_addr, rd_start); else passed++;
      for (int c = 3; c <= 60; c++) begin
         sample_en = (c % 3 == 0);
         #1;
         total++; if (wr_en !== (c % 3 == 0 && c <= 48)) $display("FAIL t3_wr_en c=%0d got %b exp %b", c, wr_en, c % 3 == 0 && c <= 48); else passed++;
         if (c % 3 == 0 && c <= 48) begin
            total++; if (wr_addr !== 4'(1 + (c - 3) / 3)) $display("FAIL t3_addr c=%0d got %0d exp %0d", c, wr_addr, (1 + (c - 3) / 3) % 16); else passed++;
         end
         tick;
      end
      sample_en = 1'b0;
      #1;
      total++; if (done !== 1'b1 || trig_addr !== 4'd1 || rd_start !== 4'd1) $display("FAIL t3_done got done=%b trig=%0d rd=%0d exp 1 1 1", done, trig_addr, rd_start); else passed++;
   endtask
   task automatic test_ignored_edges;
      int ss = 0;
      pretrig_len = 4'd4; sample_en = 1'b1; trig_in = 1'b0; arm = 1'b1;
      tick;
      arm = 1'b0;
      for (int k = 0; k < 20; k++) begin
         trig_in = (k == 1 || k == 3 || k == 6 || k >= 9);
         #1;
         ss += int'(trig_ss_rst);
         total++; if (wr_en !== (k <= 17)) $display("FAIL t4_wr_en k=%0d got %b exp %b", k, wr_en, k <= 17); else passed++;
         if (k <= 17) begin
            total++; if (wr_addr !== 4'(k)) $display("FAIL t4_addr k=%0d got %0d exp %0d", k, wr_addr, k % 16); else passed++;
         end
         tick;
      end
      #1;
      total++; if (trig_addr !== 4'd6 || rd_start !== 4'd2) $display("FAIL t4_trig got trig=%0d rd=%0d exp 6 2", trig_addr, rd_start); else passed++;
      total++; if (done !== 1'b1) $display("FAIL t4_done got %b exp 1", done); else passed++;
      total++; if (ss !== 1) $display("FAIL t4_ss_count got %0d exp 1", ss); else passed++;
   endtask
   task automatic test_abort;
      pretrig_len = 4'd4; sample_en = 1'b1; trig_in = 1'b0; arm = 1'b1;
      tick;
      arm = 1'b0;
      for (int k = 0; k < 4; k++) tick;
      trig_in = 1'b1;
      tick;
      arm = 1'b1;
      tick;
      arm = 1'b0;
      #1;
      total++; if (wr_addr !== 4'd6 || trig_ss_rst !== 1'b0 || busy !== 1'b1) $display("FAIL t5_arm_busy got addr=%0d ss=%b busy=%b exp 6 0 1", wr_addr, trig_ss_rst, busy); else passed++;
      tick; tick;
      abort = 1'b1;
      #1;
      total++; if (wr_en !== 1'b0 || busy !== 1'b1) $display("FAIL t5_abort_cycle got wr_en=%b busy=%b exp 0 1", wr_en, busy); else passed++;
      tick;
      abort = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || done !== 1'b0 || trig_en !== 1'b0 || wr_en !== 1'b0) $display("FAIL t5_idle got busy=%b done=%b trig_en=%b wr_en=%b exp 0 0 0 0", busy, done, trig_en, wr_en); else passed++;
      total++; if (trig_addr !== 4'd4 || rd_start !== 4'd0) $display("FAIL t5_keep got trig=%0d rd=%0d exp 4 0", trig_addr, rd_start); else passed++;
      trig_in = 1'b0;
   endtask
   task automatic test_rd_ack;
      pretrig_len = 4'd15; single_shot = 1'b1; sample_en = 1'b1; arm = 1'b1;
      tick;
      arm = 1'b0;
      for (int k = 0; k < 18; k++) tick;
      force_trig = 1'b1;
      #1;
      total++; if (wr_en !== 1'b1 || wr_addr !== 4'd2) $display("FAIL t6_edge_write got wr_en=%b addr=%0d exp 1 2", wr_en, wr_addr); else passed++;
      tick;
      force_trig = 1'b0;
      #1;
      total++; if (done !== 1'b1 || wr_en !== 1'b0 || wr_addr !== 4'd3) $display("FAIL t6_done1 got done=%b wr_en=%b addr=%0d exp 1 0 3", done, wr_en, wr_addr); else passed++;
      total++; if (trig_addr !== 4'd2 || rd_start !== 4'd3) $display("FAIL t6_wrap got trig=%0d rd=%0d exp 2 3", trig_addr, rd_start); else passed++;
      single_shot = 1'b0; rd_ack = 1'b1;
      tick;
      rd_ack = 1'b0;
      #1;
      total++; if (busy !== 1'b1 || done !== 1'b0 || wr_addr !== 4'd0 || trig_ss_rst !== 1'b1) $display("FAIL t6_restart got busy=%b done=%b addr=%0d ss=%b exp 1 0 0 1", busy, done, wr_addr, trig_ss_rst); else passed++;
      for (int k = 0; k < 15; k++) tick;
      force_trig = 1'b1;
      tick;
      force_trig = 1'b0;
      #1;
      total++; if (done !== 1'b1 || trig_addr !== 4'd15 || rd_start !== 4'd0) $display("FAIL t6_done2 got done=%b trig=%0d rd=%0d exp 1 15 0", done, trig_addr, rd_start); else passed++;
      single_shot = 1'b1; rd_ack = 1'b1;
      tick;
      rd_ack = 1'b0;
      tick; tick;
      #1;
      total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL t6_single_shot got done=%b busy=%b exp 1 0", done, busy); else passed++;
      arm = 1'b1;
      tick;
      arm = 1'b0;
      #1;
      total++; if (busy !== 1'b1 || wr_addr !== 4'd0 || trig_ss_rst !== 1'b1) $display("FAIL t6_rearm got busy=%b addr=%0d ss=%b exp 1 0 1", busy, wr_addr, trig_ss_rst); else passed++;
      abort = 1'b1;
      tick;
      abort = 1'b0;
      sample_en = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL t6_abort got busy=%b done=%b exp 0 0", busy, done); else passed++;
   endtask
   initial begin
      rst = 1'b1; sample_en = 1'b0; arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
      rd_ack = 1'b0; single_shot = 1'b0; trig_in = 1'b0; pretrig_len = 4'd0;
      test_reset;
      test_normal;
      test_force_zero_pre;
      test_ignored_edges;
      test_abort;
      test_rd_ack;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end
endmodule
